// File: rtl/sram_bus_arbiter_if.sv
// SRAM-like request/response bundle (req/addr_ok/data_ok) shared by the
// instruction master, the data master and the downstream port.
interface sram_bus_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// 2-to-1 SRAM-bus arbiter with pass-through issue and in-order tag FIFO steering.
// Optional macro ARB_RR_EN: round-robin tie-break instead of fixed data priority.
module sram_bus_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input logic                 clk,
  input logic                 reset,
  sram_bus_arbiter_if.slave   inst_sram,
  sram_bus_arbiter_if.slave   data_sram,
  sram_bus_arbiter_if.master  mem
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = PW + 1;

  typedef enum logic {
    SEL_INST = 1'b0,
    SEL_DATA = 1'b1
  } sel_e;

  logic          lock_q, lock_d;
  sel_e          lock_owner_q, lock_owner_d;
  logic          tag_q [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
`ifdef ARB_RR_EN
  sel_e          rr_ptr_q, rr_ptr_d;
`endif

  logic grant_vld;
  sel_e grant;
  logic owner_req;
  logic fifo_full;
  logic fifo_empty;
  logic handshake;
  logic pop;
  logic head_tag;

  // A stalled request keeps the port locked to its master until accepted or withdrawn.
  always_comb begin
    grant_vld = 1'b0;
    grant     = SEL_INST;
    if (lock_q) begin
      grant_vld = 1'b1;
      grant     = lock_owner_q;
    end else if (data_sram.req && inst_sram.req) begin
      grant_vld = 1'b1;
`ifdef ARB_RR_EN
      grant     = rr_ptr_q;
`else
      grant     = SEL_DATA;
`endif
    end else if (data_sram.req) begin
      grant_vld = 1'b1;
      grant     = SEL_DATA;
    end else if (inst_sram.req) begin
      grant_vld = 1'b1;
      grant     = SEL_INST;
    end
  end

  assign owner_req  = (grant == SEL_DATA) ? data_sram.req : inst_sram.req;
  assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign handshake  = mem.req & mem.addr_ok;
  assign pop        = mem.data_ok & ~fifo_empty;
  assign head_tag   = tag_q[rd_ptr_q];

  always_comb begin
    mem.req   = grant_vld & owner_req & ~fifo_full;
    mem.wr    = 1'b0;
    mem.size  = 2'b00;
    mem.wstrb = 4'b0000;
    mem.addr  = 32'h0;
    mem.wdata = 32'h0;
    if (grant_vld) begin
      if (grant == SEL_DATA) begin
        mem.wr    = data_sram.wr;
        mem.size  = data_sram.size;
        mem.wstrb = data_sram.wstrb;
        mem.addr  = data_sram.addr;
        mem.wdata = data_sram.wdata;
      end else begin
        mem.wr    = inst_sram.wr;
        mem.size  = inst_sram.size;
        mem.wstrb = inst_sram.wstrb;
        mem.addr  = inst_sram.addr;
        mem.wdata = inst_sram.wdata;
      end
    end
  end

  assign inst_sram.addr_ok = handshake & (grant == SEL_INST);
  assign data_sram.addr_ok = handshake & (grant == SEL_DATA);
  assign inst_sram.data_ok = pop & ~head_tag;
  assign data_sram.data_ok = pop & head_tag;
  assign inst_sram.rdata   = mem.rdata;
  assign data_sram.rdata   = mem.rdata;

  always_comb begin
    wr_ptr_d = handshake ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (handshake && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!handshake && pop) begin
      count_d = count_q - 1'b1;
    end

    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    if (mem.req && !mem.addr_ok) begin
      lock_d       = 1'b1;
      lock_owner_d = grant;
    end else if (handshake) begin
      lock_d = 1'b0;
    end else if (lock_q && !owner_req) begin
      lock_d = 1'b0;
    end

`ifdef ARB_RR_EN
    rr_ptr_d = rr_ptr_q;
    if (handshake && (grant == rr_ptr_q)) begin
      rr_ptr_d = sel_e'(~rr_ptr_q);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q       <= 1'b0;
      lock_owner_q <= SEL_INST;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
`ifdef ARB_RR_EN
      rr_ptr_q     <= SEL_INST;
`endif
    end else begin
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
`ifdef ARB_RR_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  // Tag storage needs no reset: entries are only read while counted as valid.
  for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_tag
    always_ff @(posedge clk) begin
      if (handshake && (wr_ptr_q == PW'(gi))) begin
        tag_q[gi] <= grant;
      end
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Self-checking bench for sram_bus_arbiter: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_sram_bus_arbiter;
  localparam int MAXO = 4;
  localparam logic [31:0] A_I = 32'h1c000000;
  localparam logic [31:0] A_D = 32'h1c001000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        m_req   [2];
  logic        m_wr    [2];
  logic [1:0]  m_size  [2];
  logic [3:0]  m_wstrb [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic        s_addr_ok;
  logic        s_data_ok;
  logic [31:0] s_rdata;

  sram_bus_arbiter_if inst_if ();
  sram_bus_arbiter_if data_if ();
  sram_bus_arbiter_if mem_if ();

  assign inst_if.req   = m_req[0];
  assign inst_if.wr    = m_wr[0];
  assign inst_if.size  = m_size[0];
  assign inst_if.wstrb = m_wstrb[0];
  assign inst_if.addr  = m_addr[0];
  assign inst_if.wdata = m_wdata[0];
  assign data_if.req   = m_req[1];
  assign data_if.wr    = m_wr[1];
  assign data_if.size  = m_size[1];
  assign data_if.wstrb = m_wstrb[1];
  assign data_if.addr  = m_addr[1];
  assign data_if.wdata = m_wdata[1];
  assign mem_if.addr_ok = s_addr_ok;
  assign mem_if.data_ok = s_data_ok;
  assign mem_if.rdata   = s_rdata;

  logic        obs_aok   [2];
  logic        obs_dok   [2];
  logic [31:0] obs_rdata [2];
  assign obs_aok[0]   = inst_if.addr_ok;
  assign obs_aok[1]   = data_if.addr_ok;
  assign obs_dok[0]   = inst_if.data_ok;
  assign obs_dok[1]   = data_if.data_ok;
  assign obs_rdata[0] = inst_if.rdata;
  assign obs_rdata[1] = data_if.rdata;

  sram_bus_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk       (clk),
    .reset     (rst),
    .inst_sram (inst_if),
    .data_sram (data_if),
    .mem       (mem_if)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: queue of outstanding owners, pending-lock owner, RR pointer.
  bit tq[$];
  bit locked = 1'b0;
  bit owner  = 1'b0;
  bit rrp    = 1'b0;

  bit          g_v, g;
  logic        e_mem_req, e_wr;
  logic [1:0]  e_size;
  logic [3:0]  e_wstrb;
  logic [31:0] e_addr, e_wdata;
  logic        e_aok [2];
  logic        e_dok [2];

  task automatic model_eval();
    g_v = 1'b0;
    g   = 1'b0;
    if (locked) begin
      g_v = 1'b1; g = owner;
    end else if (m_req[0] && m_req[1]) begin
      g_v = 1'b1;
`ifdef ARB_RR_EN
      g = rrp;
`else
      g = 1'b1;
`endif
    end else if (m_req[1]) begin
      g_v = 1'b1; g = 1'b1;
    end else if (m_req[0]) begin
      g_v = 1'b1; g = 1'b0;
    end
    e_mem_req = g_v && m_req[g] && (tq.size() < MAXO);
    e_wr    = g_v ? m_wr[g]    : 1'b0;
    e_size  = g_v ? m_size[g]  : 2'b0;
    e_wstrb = g_v ? m_wstrb[g] : 4'b0;
    e_addr  = g_v ? m_addr[g]  : 32'h0;
    e_wdata = g_v ? m_wdata[g] : 32'h0;
    e_aok[0] = e_mem_req && s_addr_ok && (g == 1'b0);
    e_aok[1] = e_mem_req && s_addr_ok && (g == 1'b1);
    e_dok[0] = 1'b0;
    e_dok[1] = 1'b0;
    if (s_data_ok && tq.size() > 0) e_dok[tq[0]] = 1'b1;
  endtask

  task automatic model_update();
    bit hs;
    if (rst) begin
      tq.delete();
      locked = 1'b0;
      rrp    = 1'b0;
    end else begin
      hs = e_mem_req && s_addr_ok;
      if (s_data_ok && tq.size() > 0) void'(tq.pop_front());
      if (hs) tq.push_back(g);
      if (e_mem_req && !s_addr_ok) begin
        locked = 1'b1; owner = g;
      end else if (hs) begin
        locked = 1'b0;
      end else if (locked && !m_req[owner]) begin
        locked = 1'b0;
      end
      if (hs && g == rrp) rrp = ~rrp;
    end
  endtask

  task automatic step();
    model_eval();
    if (!rst && e_mem_req && s_addr_ok)
      $display("txn issue  master=%0d addr=%h wr=%0d", g, e_addr, e_wr);
    if (!rst && (e_dok[0] || e_dok[1]))
      $display("txn resp   master=%0d rdata=%h", e_dok[1] ? 1 : 0, s_rdata);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      m_req[i] = 1'b0; m_wr[i] = 1'b0; m_size[i] = 2'b0;
      m_wstrb[i] = 4'b0; m_addr[i] = 32'h0; m_wdata[i] = 32'h0;
    end
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = 32'h0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    #1;
    n_vec++; if (mem_if.req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got=%b exp=0", mem_if.req); end
    n_vec++; if (mem_if.addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr got=%h exp=0", mem_if.addr); end
    n_vec++; if (obs_aok[0] !== 1'b0 || obs_aok[1] !== 1'b0) begin n_err++; $display("FAIL reset_addr_ok got=%b%b exp=00", obs_aok[1], obs_aok[0]); end
    rst = 1'b0;
    s_data_ok = 1'b1;
    #1;
    n_vec++; if (obs_dok[0] !== 1'b0 || obs_dok[1] !== 1'b0) begin n_err++; $display("FAIL reset_empty_data_ok got=%b%b exp=00", obs_dok[1], obs_dok[0]); end
    step();
    idle();
  endtask

  task automatic test_single_read();
    do_reset();
    m_req[0] = 1'b1; m_addr[0] = A_I; s_addr_ok = 1'b1;
    #1;
    n_vec++; if (mem_if.req !== 1'b1 || mem_if.addr !== A_I) begin n_err++; $display("FAIL single_issue got req=%b addr=%h exp req=1 addr=%h", mem_if.req, mem_if.addr, A_I); end
    n_vec++; if (obs_aok[0] !== 1'b1 || obs_aok[1] !== 1'b0) begin n_err++; $display("FAIL single_addr_ok got=%b%b exp=01", obs_aok[1], obs_aok[0]); end
    step();
    m_req[0] = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'h02800000;
    #1;
    n_vec++; if (obs_dok[0] !== 1'b1 || obs_rdata[0] !== 32'h02800000) begin n_err++; $display("FAIL single_resp got dok=%b rdata=%h exp dok=1 rdata=02800000", obs_dok[0], obs_rdata[0]); end
    n_vec++; if (obs_dok[1] !== 1'b0) begin n_err++; $display("FAIL single_data_dok got=%b exp=0", obs_dok[1]); end
    step();
    idle();
  endtask

  task automatic test_conflict();
    bit fd;
    logic [31:0] a [2];
    a[0] = A_I; a[1] = A_D;
`ifdef ARB_RR_EN
    fd = 1'b0;
`else
    fd = 1'b1;
`endif
    do_reset();
    m_req[0] = 1'b1; m_addr[0] = A_I;
    m_req[1] = 1'b1; m_addr[1] = A_D;
    s_addr_ok = 1'b1;
    #1;
    n_vec++; if (mem_if.addr !== a[fd] || obs_aok[fd] !== 1'b1 || obs_aok[~fd] !== 1'b0) begin n_err++; $display("FAIL conflict_first got addr=%h aok=%b%b exp addr=%h", mem_if.addr, obs_aok[1], obs_aok[0], a[fd]); end
    step();
    m_req[fd] = 1'b0;
    #1;
    n_vec++; if (mem_if.addr !== a[~fd] || obs_aok[~fd] !== 1'b1) begin n_err++; $display("FAIL conflict_second got addr=%h aok=%b%b exp addr=%h", mem_if.addr, obs_aok[1], obs_aok[0], a[~fd]); end
    step();
    idle();
  endtask

  task automatic test_lock();
    do_reset();
    m_req[0] = 1'b1; m_addr[0] = A_I; s_addr_ok = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin m_req[1] = 1'b1; m_addr[1] = A_D; end
      #1;
      n_vec++; if (mem_if.req !== 1'b1 || mem_if.addr !== A_I || obs_aok[1] !== 1'b0) begin n_err++; $display("FAIL lock_hold c=%0d got req=%b addr=%h daok=%b exp req=1 addr=%h daok=0", c, mem_if.req, mem_if.addr, obs_aok[1], A_I); end
      step();
    end
    s_addr_ok = 1'b1;
    #1;
    n_vec++; if (mem_if.addr !== A_I || obs_aok[0] !== 1'b1 || obs_aok[1] !== 1'b0) begin n_err++; $display("FAIL lock_accept got addr=%h aok=%b%b exp addr=%h aok=01", mem_if.addr, obs_aok[1], obs_aok[0], A_I); end
    step();
    m_req[0] = 1'b0;
    #1;
    n_vec++; if (mem_if.addr !== A_D || obs_aok[1] !== 1'b1) begin n_err++; $display("FAIL lock_next got addr=%h daok=%b exp addr=%h daok=1", mem_if.addr, obs_aok[1], A_D); end
    step();
    idle();
  endtask

  task automatic test_in_order();
    bit who;
    do_reset();
    s_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      who = (i == 1);
      m_req[0] = 1'b0; m_req[1] = 1'b0;
      m_req[who] = 1'b1; m_addr[who] = $urandom;
      #1;
      n_vec++; if (obs_aok[who] !== 1'b1) begin n_err++; $display("FAIL order_issue i=%0d got aok=%b exp=1", i, obs_aok[who]); end
      step();
    end
    idle();
    s_data_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      who = (i == 1);
      s_rdata = $urandom;
      #1;
      n_vec++; if (obs_dok[who] !== 1'b1 || obs_dok[~who] !== 1'b0 || obs_rdata[who] !== s_rdata) begin n_err++; $display("FAIL order_resp i=%0d got dok=%b%b rdata=%h exp master=%0d rdata=%h", i, obs_dok[1], obs_dok[0], obs_rdata[who], who, s_rdata); end
      step();
    end
    idle();
  endtask

  task automatic test_full();
    do_reset();
    m_req[0] = 1'b1; s_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      m_addr[0] = 32'(i * 4);
      #1;
      n_vec++; if (mem_if.req !== 1'b1) begin n_err++; $display("FAIL full_fill i=%0d got req=%b exp=1", i, mem_if.req); end
      step();
    end
    m_addr[0] = 32'h100;
    #1;
    n_vec++; if (mem_if.req !== 1'b0 || obs_aok[0] !== 1'b0) begin n_err++; $display("FAIL full_block got req=%b aok=%b exp 0 0", mem_if.req, obs_aok[0]); end
    step();
    s_data_ok = 1'b1;
    #1;
    n_vec++; if (mem_if.req !== 1'b0 || obs_dok[0] !== 1'b1) begin n_err++; $display("FAIL full_pop_cycle got req=%b dok=%b exp req=0 dok=1", mem_if.req, obs_dok[0]); end
    step();
    s_data_ok = 1'b0;
    #1;
    n_vec++; if (mem_if.req !== 1'b1 || obs_aok[0] !== 1'b1 || mem_if.addr !== 32'h100) begin n_err++; $display("FAIL full_resume got req=%b aok=%b addr=%h exp req=1 aok=1 addr=00000100", mem_if.req, obs_aok[0], mem_if.addr); end
    step();
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    s_addr_ok = 1'b1;
    m_req[0] = 1'b1; step(); m_req[0] = 1'b0;
    m_req[1] = 1'b1; step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    s_data_ok = 1'b1;
    #1;
    n_vec++; if (obs_dok[0] !== 1'b0 || obs_dok[1] !== 1'b0) begin n_err++; $display("FAIL rstmid_stale got dok=%b%b exp=00", obs_dok[1], obs_dok[0]); end
    step();
    s_data_ok = 1'b0;
    m_req[1] = 1'b1; s_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if (mem_if.req !== 1'b1) begin n_err++; $display("FAIL rstmid_cap i=%0d got req=%b exp=1", i, mem_if.req); end
      step();
    end
    #1;
    n_vec++; if (mem_if.req !== 1'b0) begin n_err++; $display("FAIL rstmid_full got req=%b exp=0", mem_if.req); end
    step();
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 600; it++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < 2; i++) begin
        m_req[i]   = ($urandom_range(0, 2) != 0);
        m_wr[i]    = 1'($urandom);
        m_size[i]  = 2'($urandom);
        m_wstrb[i] = 4'($urandom);
        m_addr[i]  = $urandom;
        m_wdata[i] = $urandom;
      end
      s_addr_ok = 1'($urandom);
      s_data_ok = ($urandom_range(0, 2) == 0);
      s_rdata   = $urandom;
      #1;
      model_eval();
      n_vec++; if (mem_if.req !== e_mem_req) begin n_err++; $display("FAIL rnd_mem_req it=%0d got=%b exp=%b", it, mem_if.req, e_mem_req); end
      n_vec++; if (mem_if.addr !== e_addr || mem_if.wdata !== e_wdata) begin n_err++; $display("FAIL rnd_addr_wdata it=%0d got=%h/%h exp=%h/%h", it, mem_if.addr, mem_if.wdata, e_addr, e_wdata); end
      n_vec++; if (mem_if.wr !== e_wr || mem_if.size !== e_size || mem_if.wstrb !== e_wstrb) begin n_err++; $display("FAIL rnd_ctrl it=%0d got=%b/%h/%h exp=%b/%h/%h", it, mem_if.wr, mem_if.size, mem_if.wstrb, e_wr, e_size, e_wstrb); end
      n_vec++; if (obs_aok[0] !== e_aok[0] || obs_aok[1] !== e_aok[1]) begin n_err++; $display("FAIL rnd_addr_ok it=%0d got=%b%b exp=%b%b", it, obs_aok[1], obs_aok[0], e_aok[1], e_aok[0]); end
      n_vec++; if (obs_dok[0] !== e_dok[0] || obs_dok[1] !== e_dok[1]) begin n_err++; $display("FAIL rnd_data_ok it=%0d got=%b%b exp=%b%b", it, obs_dok[1], obs_dok[0], e_dok[1], e_dok[0]); end
      n_vec++; if (obs_rdata[0] !== s_rdata || obs_rdata[1] !== s_rdata) begin n_err++; $display("FAIL rnd_rdata it=%0d got=%h/%h exp=%h", it, obs_rdata[0], obs_rdata[1], s_rdata); end
      step();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_single_read();
    test_conflict();
    test_lock();
    test_in_order();
    test_full();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
